// File: rtl/pipe_pkg.sv
// pipe_pkg: shared types and sizes for the pipeline hazard tracker
//   slot_t      - one tracked pipeline slot {valid, wr_en, dest, is_load}
//   NUM_REGS    - register file size
//   REG_W       - register index width
//   STALL_CNT_W - stall cycle counter width
//   is_src()    - true when a slot holds a pending write to a real register (R0 excluded)
package pipe_pkg;
    localparam int NUM_REGS    = 8;
    localparam int REG_W       = 3;
    localparam int STALL_CNT_W = 16;

    typedef struct packed {
        logic             valid;
        logic             wr_en;
        logic [REG_W-1:0] dest;
        logic             is_load;
    } slot_t;

    function automatic logic is_src(input slot_t s);
        return s.valid & s.wr_en & (s.dest != '0);
    endfunction
endpackage

// File: rtl/hazard_slot_match.sv
// hazard_slot_match: flags one source register as dependent on one tracked slot
//   slot - tracked slot contents
//   src  - decode-stage source register index
//   hit  - slot is a hazard source writing src
module hazard_slot_match
    import pipe_pkg::*;
(
    input  slot_t            slot,
    input  logic [REG_W-1:0] src,
    output logic             hit
);
    assign hit = is_src(slot) & (slot.dest == src);
endmodule

// File: rtl/pipe_hazard_tracker.sv
// pipe_hazard_tracker: RAW interlock for a 5-stage pipe (EX/MEM/WB write tracking)
//   clk           - system clock, rising edge
//   rst_n         - asynchronous active-low reset
//   issue_valid   - decode presents an instruction
//   issue_wr_en   - it writes the register file
//   issue_dest    - its destination register
//   issue_is_load - it is a memory load
//   q_rs, q_rt    - decode source fields
//   q_rt_used     - Rt is a real source operand
//   flush         - redirect; kill the presented instruction
//   stall         - hold PC and IF/ID, bubble into ID/EX
//   busy          - per-register pending-write map
//   stall_cnt     - saturating count of stall cycles
// Macro PIPE_HAZARD_FWD_EN: with full forwarding only load-use in EX interlocks;
// undefined, any pending EX or MEM write to a source interlocks.
module pipe_hazard_tracker
    import pipe_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   issue_valid,
    input  logic                   issue_wr_en,
    input  logic [REG_W-1:0]       issue_dest,
    input  logic                   issue_is_load,
    input  logic [REG_W-1:0]       q_rs,
    input  logic [REG_W-1:0]       q_rt,
    input  logic                   q_rt_used,
    input  logic                   flush,
    output logic                   stall,
    output logic [NUM_REGS-1:0]    busy,
    output logic [STALL_CNT_W-1:0] stall_cnt
);
    slot_t            ex_q, mem_q, wb_q, ex_d;
    logic [REG_W-1:0] srcs [2];
    logic [1:0]       ex_hit, src_hit;
    logic             unused_ld;

    assign srcs[0] = q_rs;
    assign srcs[1] = q_rt;

    genvar s;
    generate
        for (s = 0; s < 2; s++) begin : g_ex
            hazard_slot_match u_ex (.slot(ex_q), .src(srcs[s]), .hit(ex_hit[s]));
        end
    endgenerate

`ifdef PIPE_HAZARD_FWD_EN
    assign src_hit = ex_hit & {2{ex_q.is_load}};
`else
    logic [1:0] mem_hit;
    generate
        for (s = 0; s < 2; s++) begin : g_mem
            hazard_slot_match u_mem (.slot(mem_q), .src(srcs[s]), .hit(mem_hit[s]));
        end
    endgenerate
    assign src_hit = ex_hit | mem_hit;
`endif

    // Gated by rst_n so stall is low during reset regardless of inputs.
    assign stall = rst_n & issue_valid & ~flush & (src_hit[0] | (q_rt_used & src_hit[1]));

    assign ex_d = (issue_valid & ~stall & ~flush) ? '{1'b1, issue_wr_en, issue_dest, issue_is_load} : '0;

    // is_load only matters for EX under forwarding; keep the record uniform anyway.
    assign unused_ld = ^{ex_q.is_load, mem_q.is_load, wb_q.is_load};

    always_comb begin
        busy = '0;
        if (is_src(ex_q)) busy[ex_q.dest] = 1'b1;
        if (is_src(mem_q)) busy[mem_q.dest] = 1'b1;
        if (is_src(wb_q)) busy[wb_q.dest] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q      <= '0;
            mem_q     <= '0;
            wb_q      <= '0;
            stall_cnt <= '0;
        end else begin
            ex_q  <= ex_d;
            mem_q <= ex_q;
            wb_q  <= mem_q;
            if (stall && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_pipe_hazard_tracker.sv
// tb_pipe_hazard_tracker: directed self-checking bench for pipe_hazard_tracker
module tb_pipe_hazard_tracker;
`ifdef PIPE_HAZARD_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        issue_valid = 1'b0, issue_wr_en = 1'b0, issue_is_load = 1'b0;
    logic [2:0]  issue_dest = '0, q_rs = '0, q_rt = '0;
    logic        q_rt_used = 1'b0, flush = 1'b0;
    logic        stall;
    logic [7:0]  busy;
    logic [15:0] stall_cnt;
    logic [15:0] exp_cnt = '0;
    int          errors = 0;
    int          checks = 0;
    int          stalls;

    always #5 clk = ~clk;

    pipe_hazard_tracker dut (
        .clk(clk), .rst_n(rst_n),
        .issue_valid(issue_valid), .issue_wr_en(issue_wr_en),
        .issue_dest(issue_dest), .issue_is_load(issue_is_load),
        .q_rs(q_rs), .q_rt(q_rt), .q_rt_used(q_rt_used), .flush(flush),
        .stall(stall), .busy(busy), .stall_cnt(stall_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic set_in(input logic iv, input logic we, input logic [2:0] dst, input logic ld,
                          input logic [2:0] rs, input logic [2:0] rt, input logic rtu, input logic fl);
        issue_valid = iv; issue_wr_en = we; issue_dest = dst; issue_is_load = ld;
        q_rs = rs; q_rt = rt; q_rt_used = rtu; flush = fl;
        #1;
    endtask

    // Check stall for the current inputs, model the counter, then advance one edge.
    task automatic tick(input logic exp_stall);
        chk("stall", {31'd0, stall}, {31'd0, exp_stall});
        if (exp_stall && exp_cnt != 16'hFFFF) exp_cnt++;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < n; i++) tick(1'b0);
    endtask

    initial begin
        // Reset state, with inputs that would otherwise look busy
        set_in(1, 1, 3, 0, 3, 3, 1, 0);
        #2;
        chk("rst_stall", {31'd0, stall}, 32'd0);
        chk("rst_busy", {24'd0, busy}, 32'd0);
        chk("rst_cnt", {16'd0, stall_cnt}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(1);

        // ADD R3 then dependent Rs
        set_in(1, 1, 3, 0, 0, 0, 0, 0);
        tick(1'b0);
        chk("add_busy_ex", {24'd0, busy}, 32'h08);
        set_in(1, 0, 0, 0, 3, 0, 0, 0);
        tick(!FWD);
        chk("add_busy_mem", {24'd0, busy}, 32'h08);
        tick(!FWD);
        chk("add_busy_wb", {24'd0, busy}, 32'h08);
        chk("add_cnt", {16'd0, stall_cnt}, FWD ? 32'd0 : 32'd2);
        tick(1'b0);
        idle(3);
        chk("add_busy_clr", {24'd0, busy}, 32'h00);

        // LD R2 then dependent Rt
        set_in(1, 1, 2, 1, 0, 0, 0, 0);
        tick(1'b0);
        set_in(1, 0, 0, 0, 0, 2, 1, 0);
        tick(1'b1);
        tick(!FWD);
        tick(1'b0);
        idle(3);
        // Non-load write R2 then dependent Rt
        set_in(1, 1, 2, 0, 0, 0, 0, 0);
        tick(1'b0);
        set_in(1, 0, 0, 0, 0, 2, 1, 0);
        tick(!FWD);
        idle(4);
        chk("ld_cnt", {16'd0, stall_cnt}, {16'd0, exp_cnt});

        // Write to R0 is never a hazard
        set_in(1, 1, 0, 0, 0, 0, 0, 0);
        tick(1'b0);
        set_in(1, 0, 0, 0, 0, 0, 1, 0);
        chk("r0_busy", {24'd0, busy}, 32'h00);
        tick(1'b0);
        idle(3);

        // Flush beats a hazard and kills the presented write
        set_in(1, 1, 4, 0, 0, 0, 0, 0);
        tick(1'b0);
        set_in(1, 1, 6, 0, 4, 0, 0, 1);
        tick(1'b0);
        chk("flush_busy", {24'd0, busy}, 32'h10);
        set_in(1, 0, 0, 0, 6, 0, 0, 0);
        tick(!FWD ? 1'b0 : 1'b0);
        idle(3);

        // Rt match ignored when Rt is not a source
        set_in(1, 1, 5, 0, 0, 0, 0, 0);
        tick(1'b0);
        set_in(1, 0, 0, 0, 0, 5, 0, 0);
        tick(1'b0);
        idle(3);

        // Reset while EX and MEM both hold R5 writes
        set_in(1, 1, 5, 1, 0, 0, 0, 0);
        tick(1'b0);
        tick(1'b0);
        chk("pre_rst_busy", {24'd0, busy}, 32'h20);
        set_in(1, 0, 0, 0, 5, 0, 0, 0);
        chk("pre_rst_stall", {31'd0, stall}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", {24'd0, busy}, 32'h00);
        chk("mid_rst_stall", {31'd0, stall}, 32'd0);
        chk("mid_rst_cnt", {16'd0, stall_cnt}, 32'd0);
        exp_cnt = '0;
        #2;
        rst_n = 1'b1;
        #1;
        tick(1'b0);
        idle(3);

        // Counter saturation: repeat load-dependency bursts
        stalls = 0;
        while (stalls < 65540) begin
            set_in(1, 1, 3, 1, 0, 0, 0, 0);
            tick(1'b0);
            set_in(1, 0, 0, 0, 3, 0, 0, 0);
            tick(1'b1);
            stalls++;
            tick(!FWD);
            if (!FWD) stalls++;
        end
        chk("sat_cnt", {16'd0, stall_cnt}, 32'hFFFF);
        idle(3);
        chk("sat_hold", {16'd0, stall_cnt}, 32'hFFFF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
